rbm_load_sched: RTL and testbench
=================================

// Module: rbm_load_sched
// PURPOSE
// - Sequences the RBM DMA load datapath over all users and training loops.
// - Latches configuration on conf_done and computes rd_index/rd_length per user record.
// - Runs the rd_request/rd_grant handshake, steps the loader once per data beat, then starts compute.
// - Sits between the config registers / DMA engine and the load + compute blocks.
// PARAMETERS
// - BASE_IDX     32'd0  DMA word index of user 0's record
// - GNT_TIMEOUT  64     cycles in WAIT_GNT before re-request (TIMEOUT_EN builds only)
// PORTS
// - clk             in   1   clock
// - rst             in   1   reset, synchronous, active-high
// - conf_done       in   1   config valid; sampled in IDLE only
// - conf_num_users  in   16  users per loop
// - conf_num_visible in  16  words per user record
// - conf_num_loops  in   16  training loops
// - rd_grant        in   1   DMA accepted request (1-cycle pulse)
// - rd_beat         in   1   one data word valid on loader input this cycle
// - compute_done    in   1   compute finished current user (1-cycle pulse)
// - rd_request      out  1   DMA read request, held until rd_grant
// - rd_index        out  32  BASE_IDX + user_idx*num_visible, 32-bit wrap
// - rd_length       out  32  zero-extended num_visible
// - load_step       out  1   = rd_beat while in XFER (loader step enable)
// - compute_start   out  1   1-cycle pulse on entry to COMPUTE
// - user_idx        out  16  current user
// - loop_idx        out  16  current loop
// - done            out  1   sticky until rst or new conf_done
// BEHAVIOUR
// - Reset: state=IDLE; every output 0; internal beat_cnt 0.
// - IDLE: conf_done=1 -> latch the three counts, clear done/user_idx/loop_idx -> CHECK next cycle.
// - CHECK: num_users==0 or num_loops==0 -> DONE; else -> REQ.
// - REQ: drive rd_index/rd_length, assert rd_request; -> WAIT_GNT same edge.
//   num_visible==0 skips REQ/WAIT_GNT/XFER -> COMPUTE directly.
// - WAIT_GNT: hold rd_request/index/length stable; rd_grant -> drop rd_request next cycle, beat_cnt=0 -> XFER.
// - XFER: each rd_beat increments beat_cnt.
//   On the beat where beat_cnt+1==num_visible -> COMPUTE.
//   rd_beat in any other state is ignored; load_step stays 0.
// - COMPUTE: compute_start pulses on the entry cycle only; wait for compute_done -> NEXT.
//   compute_done coincident with the entry cycle counts.
// - NEXT: user_idx+1; user_idx==num_users-1 -> user_idx=0, loop_idx+1.
//   Last user of last loop -> DONE; else -> REQ.
// - DONE: done=1; -> IDLE the same cycle. conf_done in IDLE restarts and clears done.
// - Latency: conf_done to first rd_request = 2 cycles; rd_grant to rd_request low = 1 cycle.
// - Counter widths: 16-bit; index product computed in 32 bits before adding BASE_IDX.
// - rst mid-operation: abort immediately to reset values; pending grants/beats are discarded.
// CONFIGURATION
// - GNT_TIMEOUT_EN defined: a 16-bit wait counter runs in WAIT_GNT.
//   When it reaches GNT_TIMEOUT: rd_request goes low for 1 cycle, then re-asserts, counter clears.
//   Extra output retry_cnt[7:0] counts re-requests and saturates at 255; reset to 0.
// - GNT_TIMEOUT_EN undefined: WAIT_GNT waits indefinitely; no retry_cnt port.
// TESTING
// - users=2,visible=4,loops=1, immediate grants, 4 beats each -> rd_index 0 then 4, two compute_start, done=1.
// - users=3,visible=0,loops=2 -> no rd_request ever; 6 compute_start pulses; loop_idx reaches 1; done.
// - users=0 or loops=0 -> done=1 three cycles after conf_done; rd_request never asserted.
// - grant delayed 10 cycles -> rd_request/rd_index stable all 10 cycles; low 1 cycle after grant.
// - rst asserted in XFER after 2 of 4 beats -> all outputs 0 next cycle; fresh conf_done restarts at user 0.
// - GNT_TIMEOUT_EN, GNT_TIMEOUT=8, no grant for 20 cycles -> 2 re-request low pulses; retry_cnt=2.

Source files
------------

// File: rtl/rbm_load_sched_if.sv
// DMA read channel between the RBM load scheduler (master) and the DMA engine / loader (slave).
interface rbm_load_sched_if;
  logic        rd_request;
  logic        rd_grant;
  logic [31:0] rd_index;
  logic [31:0] rd_length;
  logic        rd_beat;
  logic        load_step;

  modport master (
    output rd_request, rd_index, rd_length, load_step,
    input  rd_grant, rd_beat
  );

  modport slave (
    input  rd_request, rd_index, rd_length, load_step,
    output rd_grant, rd_beat
  );
endinterface

// File: rtl/rbm_load_sched.sv
// Sequences RBM DMA loads over every user of every training loop, then kicks off compute per user.
// Optional GNT_TIMEOUT_EN: re-issues a stalled read request after GNT_TIMEOUT cycles and counts retries.
module rbm_load_sched #(
  parameter logic [31:0] BASE_IDX = 32'd0
`ifdef GNT_TIMEOUT_EN
  ,
  parameter int unsigned GNT_TIMEOUT = 64
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             conf_done,
  input  logic [15:0]      conf_num_users,
  input  logic [15:0]      conf_num_visible,
  input  logic [15:0]      conf_num_loops,
  input  logic             compute_done,
  output logic             compute_start,
  output logic [15:0]      user_idx,
  output logic [15:0]      loop_idx,
  output logic             done,
`ifdef GNT_TIMEOUT_EN
  output logic [7:0]       retry_cnt,
`endif
  rbm_load_sched_if.master rd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_REQ,
    S_WAIT_GNT,
    S_XFER,
    S_COMPUTE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [15:0] num_users;
  logic [15:0] num_visible;
  logic [15:0] num_loops;
  logic [15:0] beat_cnt;
  logic [15:0] req_user;
  logic [31:0] req_index;
  logic        last_user;
  logic        last_loop;
  logic        last_beat;
`ifdef GNT_TIMEOUT_EN
  logic [15:0] wait_cnt;
`endif

  assign last_user = (user_idx == num_users - 16'd1);
  assign last_loop = (loop_idx == num_loops - 16'd1);
  assign last_beat = rd.rd_beat && (beat_cnt + 16'd1 == num_visible);

  // The record address is loaded on entry to REQ, so from NEXT it must target the user being advanced to.
  assign req_user  = (state == S_NEXT) ? (last_user ? 16'd0 : user_idx + 16'd1) : user_idx;
  assign req_index = BASE_IDX + ({16'd0, req_user} * {16'd0, num_visible});

  assign rd.load_step = (state == S_XFER) && rd.rd_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (conf_done) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (num_users == 16'd0 || num_loops == 16'd0) state_nxt = S_DONE;
        else if (num_visible == 16'd0)                state_nxt = S_COMPUTE;
        else                                          state_nxt = S_REQ;
      end
      S_REQ: begin
        state_nxt = S_WAIT_GNT;
      end
      S_WAIT_GNT: begin
        if (rd.rd_grant) state_nxt = S_XFER;
      end
      S_XFER: begin
        if (last_beat) state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (compute_done) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (last_user && last_loop)     state_nxt = S_DONE;
        else if (num_visible == 16'd0)  state_nxt = S_COMPUTE;
        else                            state_nxt = S_REQ;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_users     <= '0;
      num_visible   <= '0;
      num_loops     <= '0;
      beat_cnt      <= '0;
      user_idx      <= '0;
      loop_idx      <= '0;
      done          <= 1'b0;
      compute_start <= 1'b0;
      rd.rd_request <= 1'b0;
      rd.rd_index   <= '0;
      rd.rd_length  <= '0;
`ifdef GNT_TIMEOUT_EN
      wait_cnt      <= '0;
      retry_cnt     <= '0;
`endif
    end else begin
      compute_start <= (state_nxt == S_COMPUTE) && (state != S_COMPUTE);

      case (state)
        S_IDLE: begin
          if (conf_done) begin
            num_users   <= conf_num_users;
            num_visible <= conf_num_visible;
            num_loops   <= conf_num_loops;
            user_idx    <= '0;
            loop_idx    <= '0;
            done        <= 1'b0;
          end
        end
`ifdef GNT_TIMEOUT_EN
        // A dropped request spends exactly one cycle low before being re-raised.
        S_WAIT_GNT: begin
          if (rd.rd_grant) begin
            rd.rd_request <= 1'b0;
            beat_cnt      <= '0;
            wait_cnt      <= '0;
          end else if (!rd.rd_request) begin
            rd.rd_request <= 1'b1;
          end else if (wait_cnt == 16'(GNT_TIMEOUT - 1)) begin
            rd.rd_request <= 1'b0;
            wait_cnt      <= '0;
            if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
`else
        S_WAIT_GNT: begin
          if (rd.rd_grant) begin
            rd.rd_request <= 1'b0;
            beat_cnt      <= '0;
          end
        end
`endif
        S_XFER: begin
          if (rd.rd_beat) beat_cnt <= beat_cnt + 16'd1;
        end
        // Indices freeze on the final user so they still read back the last position once done.
        S_NEXT: begin
          if (!(last_user && last_loop)) begin
            user_idx <= req_user;
            if (last_user) loop_idx <= loop_idx + 16'd1;
          end
        end
        S_DONE: begin
          done <= 1'b1;
        end
        default: begin
        end
      endcase

      if (state_nxt == S_REQ) begin
        rd.rd_request <= 1'b1;
        rd.rd_index   <= req_index;
        rd.rd_length  <= {16'd0, num_visible};
`ifdef GNT_TIMEOUT_EN
        wait_cnt      <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_rbm_load_sched.sv
// Directed self-checking bench for rbm_load_sched: a DMA/compute responder plus scoreboard queues.
module tb_rbm_load_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        conf_done;
  logic [15:0] conf_num_users;
  logic [15:0] conf_num_visible;
  logic [15:0] conf_num_loops;
  logic        compute_done;
  logic        compute_start;
  logic [15:0] user_idx;
  logic [15:0] loop_idx;
  logic        done;
`ifdef GNT_TIMEOUT_EN
  logic [7:0]  retry_cnt;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  logic [31:0] exp_idx[$];
  logic [31:0] exp_usr[$];

  rbm_load_sched_if rd_bus();

  always #5 clk = ~clk;

`ifdef GNT_TIMEOUT_EN
  rbm_load_sched #(.BASE_IDX(32'd0), .GNT_TIMEOUT(8)) dut (
`else
  rbm_load_sched #(.BASE_IDX(32'd0)) dut (
`endif
    .clk              (clk),
    .rst              (rst),
    .conf_done        (conf_done),
    .conf_num_users   (conf_num_users),
    .conf_num_visible (conf_num_visible),
    .conf_num_loops   (conf_num_loops),
    .compute_done     (compute_done),
    .compute_start    (compute_start),
    .user_idx         (user_idx),
    .loop_idx         (loop_idx),
    .done             (done),
`ifdef GNT_TIMEOUT_EN
    .retry_cnt        (retry_cnt),
`endif
    .rd               (rd_bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_cnt++;
    assert (observed === expected) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checkOutput({tag, "_rd_request"},    32'(rd_bus.rd_request), 0);
    checkOutput({tag, "_rd_index"},      rd_bus.rd_index, 0);
    checkOutput({tag, "_rd_length"},     rd_bus.rd_length, 0);
    checkOutput({tag, "_load_step"},     32'(rd_bus.load_step), 0);
    checkOutput({tag, "_compute_start"}, 32'(compute_start), 0);
    checkOutput({tag, "_user_idx"},      32'(user_idx), 0);
    checkOutput({tag, "_loop_idx"},      32'(loop_idx), 0);
    checkOutput({tag, "_done"},          32'(done), 0);
`ifdef GNT_TIMEOUT_EN
    checkOutput({tag, "_retry_cnt"},     32'(retry_cnt), 0);
`endif
  endtask

  // Fills the scoreboard with every expected request index and {loop,user} compute start, then pulses conf_done.
  task automatic applyStimulus(input int users, input int vis, input int loops);
    exp_idx.delete();
    exp_usr.delete();
    if (users != 0 && loops != 0) begin
      for (int l = 0; l < loops; l++) begin
        for (int u = 0; u < users; u++) begin
          if (vis != 0) exp_idx.push_back(32'(u * vis));
          exp_usr.push_back({16'(l), 16'(u)});
        end
      end
    end
    @(negedge clk);
    conf_num_users   = 16'(users);
    conf_num_visible = 16'(vis);
    conf_num_loops   = 16'(loops);
    conf_done        = 1'b1;
    @(negedge clk);
    conf_done        = 1'b0;
  endtask

  // Cycle-by-cycle DMA + compute responder; cycle 1 is the first cycle after conf_done was sampled.
  task automatic run_job(input int gnt_delay, input int cmp_delay, input int vis, input int abort_beats,
                         output int n_req, output int n_start, output int first_req, output int done_cyc);
    logic        req_prev;
    logic        cs_prev;
    logic        exp_step;
    logic        post_grant;
    int          gnt_cnt;
    int          beats_left;
    int          beats_done;
    int          cmp_cnt;
    logic [31:0] held_idx;
    req_prev = 1'b0; cs_prev = 1'b0; post_grant = 1'b0; held_idx = '0;
    gnt_cnt = 0; beats_left = 0; beats_done = 0; cmp_cnt = -1;
    n_req = 0; n_start = 0; first_req = -1; done_cyc = -1;
    for (int cyc = 1; cyc <= 1000; cyc++) begin
      rd_bus.rd_beat  = 1'b0;
      rd_bus.rd_grant = 1'b0;
      compute_done    = 1'b0;
      exp_step        = 1'b0;
      if (cyc == 1) checkOutput("done_cleared", 32'(done), 0);
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (abort_beats > 0 && beats_done == abort_beats) begin
        rst             = 1'b1;
        rd_bus.rd_beat  = 1'b1;
        rd_bus.rd_grant = 1'b1;
        compute_done    = 1'b1;
        return;
      end
      // Stray beats during REQ/WAIT_GNT must never reach the loader.
      if (rd_bus.rd_request && !req_prev) begin
        n_req++;
        if (first_req < 0) first_req = cyc;
        checkOutput("req_expected", 32'(exp_idx.size() != 0), 1);
        if (exp_idx.size() != 0) checkOutput("rd_index", rd_bus.rd_index, exp_idx.pop_front());
        checkOutput("rd_length", rd_bus.rd_length, vis);
        held_idx       = rd_bus.rd_index;
        gnt_cnt        = gnt_delay;
        rd_bus.rd_beat = 1'b1;
      end else if (gnt_cnt > 0) begin
        checkOutput("req_hold", 32'(rd_bus.rd_request), 1);
        checkOutput("index_hold", rd_bus.rd_index, held_idx);
        rd_bus.rd_beat = 1'b1;
        gnt_cnt--;
        if (gnt_cnt == 0) begin
          rd_bus.rd_grant = 1'b1;
          post_grant      = 1'b1;
        end
      end else if (post_grant) begin
        checkOutput("req_drop", 32'(rd_bus.rd_request), 0);
        post_grant = 1'b0;
        beats_left = vis;
      end
      if (beats_left > 0) begin
        rd_bus.rd_beat = 1'b1;
        exp_step       = 1'b1;
        beats_left--;
        beats_done++;
      end
      if (compute_start) begin
        n_start++;
        checkOutput("start_pulse", 32'(cs_prev), 0);
        checkOutput("start_expected", 32'(exp_usr.size() != 0), 1);
        if (exp_usr.size() != 0) checkOutput("loop_user", {loop_idx, user_idx}, exp_usr.pop_front());
        cmp_cnt = cmp_delay;
      end
      if (cmp_cnt == 0) begin
        compute_done = 1'b1;
        cmp_cnt      = -1;
      end else if (cmp_cnt > 0) begin
        cmp_cnt--;
      end
      req_prev = rd_bus.rd_request;
      cs_prev  = compute_start;
      #1;
      checkOutput("load_step", 32'(rd_bus.load_step), 32'(exp_step));
      @(negedge clk);
    end
    if (done_cyc < 0) checkOutput("done_seen", 32'(done), 1);
    checkOutput("index_queue_left", 32'(exp_idx.size()), 0);
    checkOutput("start_queue_left", 32'(exp_usr.size()), 0);
  endtask

  initial begin
    int n_req;
    int n_start;
    int first_req;
    int done_cyc;
`ifdef GNT_TIMEOUT_EN
    int   lows;
    logic prev_req;
`endif
    rst              = 1'b1;
    conf_done        = 1'b0;
    conf_num_users   = '0;
    conf_num_visible = '0;
    conf_num_loops   = '0;
    compute_done     = 1'b0;
    rd_bus.rd_grant  = 1'b0;
    rd_bus.rd_beat   = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    $display("[TB] two users, four words, one loop");
    applyStimulus(2, 4, 1);
    run_job(1, 0, 4, 0, n_req, n_start, first_req, done_cyc);
    checkOutput("A_first_req_cycle", first_req, 2);
    checkOutput("A_req_count", n_req, 2);
    checkOutput("A_start_count", n_start, 2);
    repeat (2) @(negedge clk);
    checkOutput("A_done_sticky", 32'(done), 1);
    checkOutput("A_req_idle", 32'(rd_bus.rd_request), 0);

    $display("[TB] zero-length records, three users, two loops");
    applyStimulus(3, 0, 2);
    run_job(1, 2, 0, 0, n_req, n_start, first_req, done_cyc);
    checkOutput("B_req_count", n_req, 0);
    checkOutput("B_start_count", n_start, 6);
    checkOutput("B_loop_idx", 32'(loop_idx), 1);
    checkOutput("B_user_idx", 32'(user_idx), 2);

    $display("[TB] empty configurations");
    applyStimulus(0, 5, 3);
    run_job(1, 0, 5, 0, n_req, n_start, first_req, done_cyc);
    checkOutput("C_done_cycle", done_cyc, 3);
    checkOutput("C_req_count", n_req, 0);
    applyStimulus(4, 2, 0);
    run_job(1, 0, 2, 0, n_req, n_start, first_req, done_cyc);
    checkOutput("D_done_cycle", done_cyc, 3);
    checkOutput("D_start_count", n_start, 0);

    $display("[TB] grant delayed ten cycles");
    applyStimulus(1, 3, 1);
    run_job(10, 1, 3, 0, n_req, n_start, first_req, done_cyc);
    checkOutput("E_req_count", n_req, 1);
    checkOutput("E_start_count", n_start, 1);

    $display("[TB] three users, two words, two loops");
    applyStimulus(3, 2, 2);
    run_job(2, 1, 2, 0, n_req, n_start, first_req, done_cyc);
    checkOutput("G_req_count", n_req, 6);
    checkOutput("G_start_count", n_start, 6);
    checkOutput("G_loop_idx", 32'(loop_idx), 1);

    $display("[TB] reset in the middle of the second transfer");
    applyStimulus(2, 4, 1);
    run_job(1, 0, 4, 6, n_req, n_start, first_req, done_cyc);
    @(negedge clk);
    check_idle_outputs("rst_mid");
    rst             = 1'b0;
    rd_bus.rd_beat  = 1'b0;
    rd_bus.rd_grant = 1'b0;
    compute_done    = 1'b0;
    applyStimulus(2, 4, 1);
    run_job(1, 0, 4, 0, n_req, n_start, first_req, done_cyc);
    checkOutput("H_first_req_cycle", first_req, 2);
    checkOutput("H_req_count", n_req, 2);

`ifdef GNT_TIMEOUT_EN
    $display("[TB] grant withheld, re-request on timeout");
    applyStimulus(1, 1, 1);
    lows     = 0;
    prev_req = 1'b0;
    for (int cyc = 1; cyc <= 21; cyc++) begin
      if (prev_req && !rd_bus.rd_request) lows++;
      prev_req = rd_bus.rd_request;
      @(negedge clk);
    end
    checkOutput("T_low_pulses", lows, 2);
    checkOutput("T_retry_cnt", 32'(retry_cnt), 2);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("T_reset");
    rst = 1'b0;
`endif

    $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
